// File: rtl/sd_fifo_rx_drainer.sv
// sd_fifo_rx_drainer: buffers deserialized SD words in a FIFO and drains them
// one at a time to memory as Wishbone classic writes at adr + offset.
module sd_fifo_rx_drainer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int MEM_OFFSET = 4,
  parameter int OFFSET_W   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [31:0]           adr,
  input  logic                  wr,
  input  logic [31:0]           dat_i,
  output logic                  full,
  output logic                  empty,
  output logic                  overrun,
  output logic [DEPTH_LOG2:0]   level,
  output logic [31:0]           m_wb_adr_o,
  output logic [31:0]           m_wb_dat_o,
  output logic [3:0]            m_wb_sel_o,
  output logic                  m_wb_we_o,
  output logic                  m_wb_cyc_o,
  output logic                  m_wb_stb_o,
  input  logic                  m_wb_ack_i,
  output logic [2:0]            m_wb_cti_o,
  output logic [1:0]            m_wb_bte_o
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_e;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0]   lvl_q, lvl_d;
  logic [31:0]           head_q, head_d, dat_q, dat_d;
  logic [OFFSET_W-1:0]   off_q, off_d;
  logic                  ovr_q, ovr_d, cyc_q, cyc_d;
  state_e                st_q, st_d;
  logic                  push, pop;

  assign full  = lvl_q == FULL_LVL;
  assign empty = lvl_q == '0;
  assign pop   = en && st_q == IDLE && !empty;
  // a full FIFO still accepts a push when the same cycle frees a slot
  assign push  = en && wr && (!full || pop);

  always_comb begin
    wp_d   = push ? wp_q + 1'b1 : wp_q;
    rp_d   = pop ? rp_q + 1'b1 : rp_q;
    lvl_d  = lvl_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
    head_d = pop ? mem_q[rp_q] : head_q;
    ovr_d  = ovr_q | (en & wr & full & !pop);
    st_d   = st_q;
    dat_d  = dat_q;
    cyc_d  = cyc_q;
    off_d  = off_q;
    case (st_q)
      IDLE:  st_d = pop ? LOAD : IDLE;
      LOAD: begin
        dat_d = head_q;
        cyc_d = 1'b1;
        st_d  = WRITE;
      end
      WRITE: if (m_wb_ack_i) begin
        cyc_d = 1'b0;
        off_d = off_q + OFFSET_W'(MEM_OFFSET);
        st_d  = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (!en) begin
      wp_d  = '0;
      rp_d  = '0;
      lvl_d = '0;
      ovr_d = 1'b0;
      st_d  = IDLE;
      cyc_d = 1'b0;
      off_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      head_q <= '0;
      dat_q  <= '0;
      off_q  <= '0;
      ovr_q  <= 1'b0;
      cyc_q  <= 1'b0;
      st_q   <= IDLE;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      lvl_q  <= lvl_d;
      head_q <= head_d;
      dat_q  <= dat_d;
      off_q  <= off_d;
      ovr_q  <= ovr_d;
      cyc_q  <= cyc_d;
      st_q   <= st_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= dat_i;
  end

  assign overrun    = ovr_q;
  assign level      = lvl_q;
  assign m_wb_adr_o = adr + 32'(off_q);
  assign m_wb_dat_o = dat_q;
  assign m_wb_sel_o = 4'b1111;
  assign m_wb_we_o  = cyc_q;
  assign m_wb_cyc_o = cyc_q;
  assign m_wb_stb_o = cyc_q;
  assign m_wb_cti_o = 3'b000;
  assign m_wb_bte_o = 2'b00;
endmodule

// File: tb/tb_sd_fifo_rx_drainer.sv
// tb_sd_fifo_rx_drainer: directed and random pushes against a queue-based
// model of the FIFO, drain engine timing and expected write sequence.
module tb_sd_fifo_rx_drainer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [31:0] adr = '0;
  logic        wr = 1'b0;
  logic [31:0] dat_i = '0;
  logic        full, empty, overrun;
  logic [4:0]  level;
  logic [31:0] m_wb_adr_o, m_wb_dat_o;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_ack_i;
  logic [2:0]  m_wb_cti_o;
  logic [1:0]  m_wb_bte_o;

  sd_fifo_rx_drainer dut (
    .clk(clk), .rst(rst), .en(en), .adr(adr), .wr(wr), .dat_i(dat_i),
    .full(full), .empty(empty), .overrun(overrun), .level(level),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_sel_o(m_wb_sel_o),
    .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
    .m_wb_ack_i(m_wb_ack_i), .m_wb_cti_o(m_wb_cti_o), .m_wb_bte_o(m_wb_bte_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wt = 0;
  int cnt = 0;
  bit ack_en = 1'b1;
  bit ack_force = 1'b0;

  // slave responder: ack once the strobe has been up for wt cycles
  always @(posedge clk) cnt <= (m_wb_cyc_o && !m_wb_ack_i) ? cnt + 1 : 0;
  assign m_wb_ack_i = ack_force | (m_wb_cyc_o & ack_en & (cnt >= wt));

  logic [31:0] mq[$];
  logic [63:0] infl[$];
  int          busy = 0;
  int unsigned off_m = 0;
  bit          ovr_m = 1'b0;
  int          nwr = 0;
  logic [31:0] last_adr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock of the reference: a word leaves the FIFO when the engine is free,
  // then occupies it for one load cycle plus wt+1 write cycles
  task model_step();
    bit pop, acc;
    if (!rst || !en) begin
      mq.delete();
      infl.delete();
      busy = 0;
      off_m = 0;
      ovr_m = 1'b0;
    end else begin
      pop = busy == 0 && mq.size() > 0;
      acc = wr && (mq.size() < 16 || pop);
      if (wr && !acc) ovr_m = 1'b1;
      if (pop) begin
        infl.push_back({adr + off_m, mq.pop_front()});
        busy = 2 + wt;
      end else if (busy > 1 || (busy == 1 && ack_en)) begin
        busy--;
        if (busy == 0) off_m = (off_m + 4) % 512;
      end
      if (acc) mq.push_back(dat_i);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("level", 32'(level), mq.size());
    chk("full", 32'(full), 32'(mq.size() == 16));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("overrun", 32'(overrun), 32'(ovr_m));
    chk("cyc", 32'(m_wb_cyc_o), 32'(busy >= 1 && busy <= wt + 1));
    chk("stb", 32'(m_wb_stb_o), 32'(busy >= 1 && busy <= wt + 1));
    chk("adr_out", m_wb_adr_o, adr + off_m);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (mq.size() != 0 || busy != 0); i++) cycle();
    cycle();
    chk("drain_pending", infl.size(), 0);
    chk("drain_level", 32'(level), 0);
  endtask

  // bus monitor: every accepted write must match the oldest expected one
  always @(negedge clk) begin
    if (rst && en && m_wb_cyc_o && m_wb_stb_o && m_wb_ack_i) begin
      chk("write_expected", 32'(infl.size() != 0), 1);
      if (infl.size() != 0) begin
        logic [63:0] e;
        e = infl.pop_front();
        chk("wb_adr", m_wb_adr_o, e[63:32]);
        chk("wb_dat", m_wb_dat_o, e[31:0]);
        chk("wb_sel", 32'(m_wb_sel_o), 32'hF);
        chk("wb_we", 32'(m_wb_we_o), 1);
        chk("wb_cti_bte", {27'd0, m_wb_cti_o, m_wb_bte_o}, 0);
        nwr++;
        last_adr = m_wb_adr_o;
      end
    end
  end

  initial begin
    int n0;
    // reset held with pushes and a forced ack
    ack_force = 1'b1;
    en = 1'b1;
    adr = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      wr = i[0];
      dat_i = $urandom;
      cycle();
    end
    chk("rst_empty", 32'(empty), 1);
    chk("rst_cyc", 32'(m_wb_cyc_o), 0);
    chk("rst_adr", m_wb_adr_o, 32'h1000);
    wr = 1'b0;
    ack_force = 1'b0;
    rst = 1'b1;
    cycle();
    // single word, zero-wait ack, 3-clock latency to cyc
    wt = 0;
    wr = 1'b1;
    dat_i = 32'hDEADBEEF;
    cycle();
    wr = 1'b0;
    cycle();
    chk("lat_cyc_early", 32'(m_wb_cyc_o), 0);
    cycle();
    chk("lat_cyc_rise", 32'(m_wb_cyc_o), 1);
    chk("single_dat", m_wb_dat_o, 32'hDEADBEEF);
    drain();
    chk("single_nwr", nwr, 1);
    // 16-word burst, two wait states
    en = 1'b0;
    cycle();
    en = 1'b1;
    wt = 2;
    n0 = nwr;
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1;
      dat_i = $urandom;
      cycle();
    end
    wr = 1'b0;
    drain();
    chk("burst_nwr", nwr - n0, 16);
    chk("burst_last_adr", last_adr, 32'h103C);
    chk("burst_ovr", 32'(overrun), 0);
    // random traffic, may overflow and collide push with pop at full
    en = 1'b0;
    cycle();
    en = 1'b1;
    adr = $urandom & 32'hFFFF_FFFC;
    wt = $urandom_range(0, 3);
    for (int i = 0; i < 120; i++) begin
      wr = ($urandom % 10) < 7;
      dat_i = $urandom;
      cycle();
    end
    wr = 1'b0;
    drain();
    // overrun with a stalled slave
    en = 1'b0;
    cycle();
    en = 1'b1;
    adr = 32'h1000;
    wt = 0;
    ack_en = 1'b0;
    n0 = nwr;
    for (int i = 0; i < 18; i++) begin
      wr = 1'b1;
      dat_i = 32'h100 + i;
      cycle();
    end
    wr = 1'b0;
    chk("ovr_full", 32'(full), 1);
    chk("ovr_set", 32'(overrun), 1);
    ack_en = 1'b1;
    drain();
    chk("ovr_nwr", nwr - n0, 17);
    chk("ovr_sticky", 32'(overrun), 1);
    en = 1'b0;
    cycle();
    chk("ovr_clear", 32'(overrun), 0);
    // abort mid-write
    en = 1'b1;
    wt = 3;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1;
      dat_i = $urandom;
      cycle();
    end
    wr = 1'b0;
    for (int i = 0; i < 20 && !(busy >= 2 && busy <= wt); i++) cycle();
    chk("abort_stb_high", 32'(m_wb_stb_o), 1);
    en = 1'b0;
    cycle();
    chk("abort_cyc", 32'(m_wb_cyc_o), 0);
    chk("abort_level", 32'(level), 0);
    chk("abort_adr", m_wb_adr_o, 32'h1000);
    en = 1'b1;
    wr = 1'b1;
    dat_i = 32'h1;
    cycle();
    wr = 1'b0;
    n0 = nwr;
    drain();
    chk("abort_rewrite_adr", last_adr, 32'h1000);
    chk("abort_rewrite_n", nwr - n0, 1);
    // offset wrap after 128 writes
    en = 1'b0;
    adr = 32'h2000;
    cycle();
    en = 1'b1;
    wt = 0;
    n0 = nwr;
    for (int i = 0; i < 129; ) begin
      wr = mq.size() < 15;
      dat_i = $urandom;
      if (wr) i++;
      cycle();
    end
    wr = 1'b0;
    drain();
    chk("wrap_nwr", nwr - n0, 129);
    chk("wrap_adr", last_adr, 32'h2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_fifo_rx_drainer.md
Name: sd_fifo_rx_drainer

Overview:
- Receive-direction counterpart of the SD controller's TX filler.
- Serial-side data words are pushed into an internal synchronous FIFO.
- A Wishbone classic master pops them one at a time and writes them to system memory at `adr + offset`.
- Sits between the SD data-line deserializer and the WB bus; single clock domain (any CDC is upstream).

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in 32-bit words (default 16 words).
- MEM_OFFSET, 4, byte increment added to offset after each acknowledged write.
- OFFSET_W, 9, width of the offset counter; wraps modulo 2^OFFSET_W.

Ports:
- clk  in  1  system/WB clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  drain enable; low = flush FIFO, clear offset, abort any bus cycle.
- adr  in  32  base byte address of the destination buffer.
- wr  in  1  push dat_i into FIFO this cycle.
- dat_i  in  32  word from deserializer.
- full  out  1  FIFO holds 2^DEPTH_LOG2 words.
- empty  out  1  FIFO holds 0 words.
- overrun  out  1  sticky: a push was attempted while full; cleared by en low or reset.
- level  out  DEPTH_LOG2+1  current FIFO occupancy.
- m_wb_adr_o  out  32  adr + zero-extended offset.
- m_wb_dat_o  out  32  registered write data.
- m_wb_sel_o  out  4  constant 4'b1111.
- m_wb_we_o  out  1  write strobe qualifier.
- m_wb_cyc_o  out  1  WB cycle.
- m_wb_stb_o  out  1  WB strobe.
- m_wb_ack_i  in  1  WB acknowledge.
- m_wb_cti_o  out  3  constant 3'b000 (classic).
- m_wb_bte_o  out  2  constant 2'b00.

Behaviour:
- Reset (rst=0): FIFO pointers 0, empty=1, full=0, level=0, overrun=0, offset=0, m_wb_dat_o=0, cyc/stb/we=0, FSM=IDLE. Applies immediately; any bus cycle in flight is dropped.
- FIFO push/pop:
  - Push when wr & en & !full.
  - A push while full is discarded and sets overrun.
  - Pop is internal only.
  - Simultaneous push and pop: level unchanged, both accepted (push is allowed when full only if a pop happens in the same cycle).
  - Pointers wrap modulo depth.
  - Pushes while en=0 are ignored and do not set overrun.
- FSM:
  - IDLE: if en & !empty, pop the head word (level decrements next cycle) → LOAD.
  - LOAD: m_wb_dat_o <= popped word; cyc=stb=we=1 next cycle → WRITE.
  - WRITE: hold cyc/stb/we/adr/dat stable until m_wb_ack_i. On the ack cycle: cyc, stb and we go 0 next cycle, offset <= offset+MEM_OFFSET → IDLE.
  - Ack outside WRITE is ignored.
- Throughput: one word per 3 cycles with zero-wait ack. Minimum latency from wr (into empty FIFO) to cyc rising is 3 clocks.
- en falls (any state): next cycle cyc/stb/we=0, FSM=IDLE, offset=0, FIFO flushed (empty=1, level=0), overrun=0. A word in LOAD/WRITE is lost; no partial ack accounting.
- adr is sampled combinationally; it must stay stable while en=1.
- offset wraps to 0 after 2^OFFSET_W; no error flag.

Test Plan:
- Reset: hold rst=0 with wr pulses and ack=1 → empty=1, level=0, cyc=stb=we=0, m_wb_adr_o=adr.
- Single word: en=1, adr=0x1000, push 0xDEADBEEF, ack one cycle after stb → exactly one write at 0x1000 with data 0xDEADBEEF, sel=F; cyc rises 3 clocks after wr.
- Burst of 16 pushes back-to-back, ack with 2 wait states → full=1 after the 16th push (if no pops yet). Writes to 0x1000, 0x1004, …, 0x103C in order; level returns to 0; overrun=0.
- Overrun: stall ack, push 18 words → full holds, overrun=1, only the first 16 words (plus those popped) are written; overrun clears on en=0.
- Abort: drop en mid-WRITE with stb high → cyc/stb low next clock, level=0, offset=0; re-enable and push 0x1 → write goes to adr+0.
- Wrap: with OFFSET_W=9, perform 128 writes → 129th write address = adr+0x000.
